data_buffer_ctrl: RTL
=====================

DATA_BUFFER_CTRL -- requirements
Module: data_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter CYCLES, default 8, giving the number of data beats per buffer capture (range 2..255).
REQ-002 The block SHALL have parameter SIZE, default 16, giving the data word width in bits.
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have port req, input, 2 bits, per-requester capture request (bit i = requester i).
REQ-006 The block SHALL have port data0, input, SIZE bits, the requester 0 data word.
REQ-007 The block SHALL have port data1, input, SIZE bits, the requester 1 data word.
REQ-008 The block SHALL have port buf_start, output, 1 bit, the start strobe to the data buffer.
REQ-009 The block SHALL have port buf_data, output, SIZE bits, the data word to the data buffer.
REQ-010 The block SHALL have port gnt, output, 2 bits, the one-hot grant of the buffer to a requester.
REQ-011 The block SHALL have port busy, output, 1 bit, high while the buffer is owned.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-013 The block SHALL have port beat_cnt, output, 8 bits, the index of the current capture beat.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, START, CAPTURE and DONE.
REQ-015 In IDLE with req==0, the FSM SHALL stay in IDLE; gnt, busy, buf_start and done SHALL be 0.
REQ-016 In IDLE with req!=0, the FSM SHALL register a one-hot gnt and move to START on the next edge.
REQ-017 Arbitration SHALL be round-robin via a 1-bit pointer: if both requesters request, the one not granted last wins; if only one requests, it wins.
REQ-018 The arbitration pointer SHALL update only on entry to DONE.
REQ-019 The START state SHALL last exactly one cycle with buf_start=1 and beat_cnt=0, then move to CAPTURE.
REQ-020 In CAPTURE, beat_cnt SHALL increment by 1 per cycle from 1 to CYCLES-1; after the beat_cnt==CYCLES-1 cycle the FSM SHALL move to DONE.
REQ-021 The DONE state SHALL last one cycle with done=1 and gnt still asserted, then move to IDLE with gnt=0.
REQ-022 Capture latency SHALL be fixed: the req-sampled edge to the done pulse is CYCLES+2 cycles.
REQ-023 buf_data SHALL be combinational: data0 when gnt[0], data1 when gnt[1], otherwise 0.
REQ-024 busy SHALL equal the OR of the gnt bits.
REQ-025 gnt SHALL never be 2'b11.
REQ-026 req SHALL be sampled only in IDLE; deasserting or changing req during START/CAPTURE/DONE SHALL NOT abort or alter the capture.
REQ-027 A request still held on return to IDLE SHALL be arbitrated on the first IDLE cycle, so back-to-back captures are separated by exactly one IDLE cycle.
REQ-028 beat_cnt SHALL read 0 in IDLE and DONE.

Reset
REQ-029 reset_n==0 at a rising edge SHALL force state IDLE, gnt=0, busy=0, buf_start=0, done=0, beat_cnt=0, and the pointer favouring requester 0; this applies in any state, including mid-capture.
REQ-030 Outputs SHALL NOT change asynchronously on reset_n.
REQ-031 After reset release, the first arbitration SHALL happen on the first edge with reset_n==1.

Verification
REQ-032 Single request: req=01, data0=16'hA5A5 -> gnt=01 next cycle; buf_start for 1 cycle with buf_data=A5A5; beat_cnt 0..7; done at cycle 10; then gnt=00.
REQ-033 Contention: req=11 held continuously -> grants alternate 01, 10, 01; each separated by one IDLE cycle; done pulses every 11 cycles.
REQ-034 Mid-capture drop: req=10, then req=00 at beat 3 -> capture runs to beat_cnt=7; done asserts; gnt1 held throughout.
REQ-035 Reset mid-capture: reset_n=0 at beat 4 -> next edge gnt=00, beat_cnt=0, no done pulse; with req=11 after release, requester 0 is granted first.
REQ-036 CYCLES=2 build: req=01 -> beat_cnt 0,1; done at cycle 4.
REQ-037 Every cycle, the bench SHALL assert gnt!=11, busy==|gnt, and that buf_data matches the granted data input (0 when idle).

Source files
------------

// File: rtl/data_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_buffer_ctrl
// Description : Two-requester round-robin owner of a data buffer; grants one
//               requester, strobes buffer start, then counts CYCLES beats.
// Revision    : 1.0 - initial release
// ============================================================================
module data_buffer_ctrl #(
  parameter int CYCLES = 8,
  parameter int SIZE   = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      req,
  input  logic [SIZE-1:0] data0,
  input  logic [SIZE-1:0] data1,
  output logic            buf_start,
  output logic [SIZE-1:0] buf_data,
  output logic [1:0]      gnt,
  output logic            busy,
  output logic            done,
  output logic [7:0]      beat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(CYCLES - 1);

  state_t      state_q;
  logic [1:0]  gnt_q;
  logic        buf_start_q;
  logic        done_q;
  logic [7:0]  beat_q;
  logic        fav_q;      // requester that wins when both request
  logic [1:0]  arb_gnt_d;

  always_comb begin
    arb_gnt_d = 2'b00;
    if (req == 2'b11) begin
      arb_gnt_d = fav_q ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      arb_gnt_d = 2'b01;
    end else if (req[1]) begin
      arb_gnt_d = 2'b10;
    end
  end

  // In IDLE the grant is registered first; the following edge enters START,
  // so a granted-but-not-started cycle keeps req from being resampled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'b00;
      buf_start_q <= 1'b0;
      done_q      <= 1'b0;
      beat_q      <= 8'd0;
      fav_q       <= 1'b0;
    end else begin
      buf_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          beat_q <= 8'd0;
          if (gnt_q != 2'b00) begin
            state_q     <= S_START;
            buf_start_q <= 1'b1;
          end else begin
            gnt_q <= arb_gnt_d;
          end
        end
        S_START: begin
          state_q <= S_CAPTURE;
          beat_q  <= 8'd1;
        end
        S_CAPTURE: begin
          if (beat_q == LAST_BEAT) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            beat_q  <= 8'd0;
            fav_q   <= gnt_q[0];
          end else begin
            beat_q <= beat_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          gnt_q   <= 2'b00;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = |gnt_q;
  assign buf_start = buf_start_q;
  assign done      = done_q;
  assign beat_cnt  = beat_q;
  assign buf_data  = gnt_q[0] ? data0 : (gnt_q[1] ? data1 : '0);

endmodule
`default_nettype wire
